// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-requester register-file write arbiter
// Round-robin grant between ALU writeback (0) and load unit (1), one registered write strobe per transfer.
module regfile_wr_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [7:0]        wr_count
);

  logic              prio_q, prio_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic              grant_ok;
  logic              xfer;

  // prio only matters when both request; a lone requester always wins.
  always_comb begin
    grant_ok = !rst && !hold;
    ack0     = grant_ok && req0 && (!req1 || !prio_q);
    ack1     = grant_ok && req1 && (!req0 ||  prio_q);
    xfer     = ack0 || ack1;
  end

  always_comb begin
    prio_d     = prio_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_count_d = wr_count_q;
    if (xfer) begin
      // The requester just served drops to lowest priority.
      prio_d     = ack0;
      wr_en_d    = 1'b1;
      wr_addr_d  = ack0 ? addr0 : addr1;
      wr_data_d  = ack0 ? data0 : data1;
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_count_q <= 8'd0;
    end else begin
      prio_q     <= prio_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;

endmodule
